// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle CPU control unit: state enum, opcodes,
// mux-select encodings and the packed control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_SHIMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch: which execution path an opcode takes.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDIEX;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control-word lookup; outputs not set for a state
// stay at 0.
module multicycle_control_decode
  import multicycle_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = ALUB_SHIMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALUB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register, next-state logic, pc_en gating
// and reset forcing. Define MULTICYCLE_MEM_WAIT_EN to stall memory states on mem_ready.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_en,
  output logic           ir_write,
  output logic           mem_write,
  output logic           reg_write,
  output logic           iord,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     dbg_state
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_raw, ctrl_g;
  logic       mem_ok;
  logic       mem_state;
  logic [5:0] op6;

  assign op6 = 6'(opcode);

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  multicycle_control_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_dispatch(op6);
      S_MEMADR: state_d = (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While a memory access is pending, suppress architectural writes; the
  // store strobe itself stays up for the whole MEMWR stay.
  always_comb begin
    ctrl_g = ctrl_raw;
    if (mem_state && !mem_ok) begin
      ctrl_g.ir_write   = 1'b0;
      ctrl_g.pc_write   = 1'b0;
      ctrl_g.reg_write  = 1'b0;
      ctrl_g.instr_done = 1'b0;
    end
  end

  // Reset forces the whole control word low without waiting for a clock.
  assign pc_en      = !rst && (ctrl_g.pc_write || (ctrl_g.branch && zero));
  assign ir_write   = !rst && ctrl_g.ir_write;
  assign mem_write  = !rst && ctrl_g.mem_write;
  assign reg_write  = !rst && ctrl_g.reg_write;
  assign iord       = !rst && ctrl_g.iord;
  assign mem_to_reg = !rst && ctrl_g.mem_to_reg;
  assign reg_dst    = !rst && ctrl_g.reg_dst;
  assign alu_src_a  = !rst && ctrl_g.alu_src_a;
  assign alu_src_b  = rst ? 2'b00 : ctrl_g.alu_src_b;
  assign alu_op     = rst ? 2'b00 : ctrl_g.alu_op;
  assign pc_src     = rst ? 2'b00 : ctrl_g.pc_src;
  assign instr_done = !rst && ctrl_g.instr_done;
  assign illegal_op = !rst && ctrl_g.illegal_op;
  assign dbg_state  = state_q;

endmodule
